// File: rtl/armleobus_arb_pkg.sv
// Shared types for the two-master ArmleoBus arbiter.
package armleobus_arb_pkg;

  localparam int ARB_PORT_COUNT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/armleobus_defs.svh
// ArmleoBus command and response encodings shared by bus masters, slaves and interconnect.
`ifndef ARMLEOBUS_DEFS_SVH
`define ARMLEOBUS_DEFS_SVH

`define ARMLEOBUS_CMD_NONE          3'd0
`define ARMLEOBUS_CMD_READ          3'd1
`define ARMLEOBUS_CMD_WRITE         3'd2

`define ARMLEOBUS_RESPONSE_SUCCESS  3'd0
`define ARMLEOBUS_UNKNOWN_ADDRESS   3'd2
`define ARMLEOBUS_INVALID_OPERATION 3'd3

`endif

// File: rtl/armleobus_arbiter2.sv
// Two-master to one-slave ArmleoBus arbiter: round-robin pick, registered grant,
// grant held until the slave signals done or the granted master withdraws.
//
//   state  | meaning
//   IDLE   | no grant, slave port driven to zero
//   GRANT0 | master 0 owns the slave port
//   GRANT1 | master 1 owns the slave port
`include "armleobus_defs.svh"

module armleobus_arbiter2
  import armleobus_arb_pkg::*;
#(
  parameter int ADDRESS_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 m0_transaction,
  input  logic [2:0]           m0_cmd,
  input  logic [ADDRESS_W-1:0] m0_address,
  input  logic [31:0]          m0_wdata,
  input  logic [3:0]           m0_wbyte_enable,
  output logic                 m0_transaction_done,
  output logic [2:0]           m0_transaction_response,
  output logic [31:0]          m0_rdata,

  input  logic                 m1_transaction,
  input  logic [2:0]           m1_cmd,
  input  logic [ADDRESS_W-1:0] m1_address,
  input  logic [31:0]          m1_wdata,
  input  logic [3:0]           m1_wbyte_enable,
  output logic                 m1_transaction_done,
  output logic [2:0]           m1_transaction_response,
  output logic [31:0]          m1_rdata,

  output logic                 s_transaction,
  output logic [2:0]           s_cmd,
  output logic [ADDRESS_W-1:0] s_address,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wbyte_enable,
  input  logic                 s_transaction_done,
  input  logic [2:0]           s_transaction_response,
  input  logic [31:0]          s_rdata
);

  logic [ARB_PORT_COUNT-1:0] req;
  arb_state_t                state, state_nxt;
  logic                      last_served, last_served_nxt;

  assign req[0] = m0_transaction && (m0_cmd != `ARMLEOBUS_CMD_NONE);
  assign req[1] = m1_transaction && (m1_cmd != `ARMLEOBUS_CMD_NONE);

  // On a tie the master that was not served last wins.
  function automatic arb_state_t pick(input logic [ARB_PORT_COUNT-1:0] r, input logic last);
    if (r[0] && r[1]) return last ? GRANT0 : GRANT1;
    else if (r[0])    return GRANT0;
    else if (r[1])    return GRANT1;
    else              return IDLE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
    end
  end

  // The finishing master's own request is not re-arbitrated in its done cycle.
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    case (state)
      IDLE: state_nxt = pick(req, last_served);
      GRANT0: begin
        if (s_transaction_done) begin
          last_served_nxt = 1'b0;
          state_nxt       = req[1] ? GRANT1 : IDLE;
        end else if (!m0_transaction) begin
          state_nxt = IDLE;
        end
      end
      GRANT1: begin
        if (s_transaction_done) begin
          last_served_nxt = 1'b1;
          state_nxt       = req[0] ? GRANT0 : IDLE;
        end else if (!m1_transaction) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_transaction           = 1'b0;
    s_cmd                   = `ARMLEOBUS_CMD_NONE;
    s_address               = '0;
    s_wdata                 = 32'h0;
    s_wbyte_enable          = 4'h0;
    m0_transaction_done     = 1'b0;
    m0_transaction_response = `ARMLEOBUS_RESPONSE_SUCCESS;
    m1_transaction_done     = 1'b0;
    m1_transaction_response = `ARMLEOBUS_RESPONSE_SUCCESS;
    case (state)
      GRANT0: begin
        s_transaction           = m0_transaction;
        s_cmd                   = m0_cmd;
        s_address               = m0_address;
        s_wdata                 = m0_wdata;
        s_wbyte_enable          = m0_wbyte_enable;
        m0_transaction_done     = s_transaction_done;
        m0_transaction_response = s_transaction_response;
      end
      GRANT1: begin
        s_transaction           = m1_transaction;
        s_cmd                   = m1_cmd;
        s_address               = m1_address;
        s_wdata                 = m1_wdata;
        s_wbyte_enable          = m1_wbyte_enable;
        m1_transaction_done     = s_transaction_done;
        m1_transaction_response = s_transaction_response;
      end
      default: ;
    endcase
  end

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule
